shift_arbiter: RTL and testbench
================================

SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, datapath width; only N=32 supported.
REQ-002 SHALL have clk  input  1  rising-edge clock.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have a_valid, b_valid  input  1 each  requester A/B operation valid.
REQ-005 SHALL have a_ready, b_ready  output  1 each  requester A/B operation accepted this cycle.
REQ-006 SHALL have a_data, b_data  input  N each  operand to shift.
REQ-007 SHALL have a_shamt, b_shamt  input  $clog2(N) each  shift amount.
REQ-008 SHALL have a_op, b_op  input  2 each  shift_op_t: SLL=00, SRL=01, SRA=10, 11 reserved.
REQ-009 SHALL have out_valid  output  1  result valid.
REQ-010 SHALL have out_ready  input  1  consumer accepts result.
REQ-011 SHALL have out_data  output  N  shifted result.
REQ-012 SHALL have out_id  output  1  originating requester, 0=A, 1=B.
REQ-013 SHALL have out_err  output  1  result came from reserved op 11.

Function
REQ-014 Two states: EMPTY (out_valid=0), FULL (out_valid=1); single output register, one shared shift unit.
REQ-015 accept = !out_valid | out_ready; no transfer while accept=0, both readies 0.
REQ-016 Grant: only one valid -> that one; both valid -> requester not granted most recently; neither -> no grant.
REQ-017 a_ready = accept & grant_A, b_ready = accept & grant_B; never both 1; readies SHALL NOT depend on out_data.
REQ-018 On a_valid&a_ready (or B), next edge loads out_data, out_id, out_err, sets out_valid=1: latency exactly 1 cycle.
REQ-019 SLL fills zeros at LSB; SRL fills zeros at MSB; SRA fills copies of operand bit N-1; shamt=0 returns operand unchanged.
REQ-020 Op 11: out_data=0, out_err=1; otherwise out_err=0.
REQ-021 out_valid&out_ready with no new grant -> out_valid=0 next edge (FULL->EMPTY).
REQ-022 out_valid&out_ready with new grant same cycle -> register reloads, out_valid stays 1 (back-to-back, full throughput).
REQ-023 While out_valid&!out_ready, out_data/out_id/out_err SHALL hold stable.
REQ-024 Priority pointer updates only on an actual transfer; a stalled requester keeps priority for the next contested cycle.
REQ-025 Requester may drop valid before ready without effect; no state is retained for unaccepted requests.

Reset
REQ-026 rst_n low asynchronously forces out_valid=0, out_data=0, out_id=0, out_err=0, priority pointer to A, stats counters 0.
REQ-027 Reset mid-FULL discards held result; first contested grant after reset goes to A.

Configuration
REQ-028 Macro SHIFT_ARBITER_STATS_EN defined: adds outputs grant_cnt_a, grant_cnt_b (16 bits each), incremented per accepted transfer of that requester, wrapping 0xFFFF->0.
REQ-029 Macro undefined: ports and counters absent; all other behaviour identical.

Structure
REQ-030 Package shift_pkg SHALL hold shift_op_t enum and constant SHIFT_N=32.
REQ-031 Sub-module shift_unit (combinational: operand, shamt, op -> result, err) SHALL implement SLL/SRL/SRA; shift_arbiter instantiates exactly one.

Verification
REQ-032 A only: a_data=0x8000_0000, shamt=4, op=SRA -> a_ready=1, next cycle out_valid=1, out_data=0xF800_0000, out_id=0.
REQ-033 Both valid every cycle, out_ready=1: grants alternate A,B,A,B starting with A after reset; out_valid stays 1 continuously.
REQ-034 B: data=0x0000_0001, shamt=31, op=SLL with out_ready=0 for 3 cycles -> out_data=0x8000_0000 held stable, a_ready=b_ready=0 until out_ready=1.
REQ-035 A op=11 data=0xFFFF_FFFF -> out_data=0, out_err=1; following SRL shamt=0 of 0x1234_5678 -> 0x1234_5678, out_err=0.
REQ-036 rst_n pulsed low while FULL -> out_valid drops immediately without clock; stats (if SHIFT_ARBITER_STATS_EN) read 0; next contested grant = A.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and constants for the two-requester shifter arbiter.
package shift_pkg;

  localparam int SHIFT_N = 32;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_RSV = 2'b11
  } shift_op_t;

endpackage

// File: rtl/shift_unit.sv
// Combinational barrel shifter with SLL/SRL/SRA; op 11 yields zero with err set.
// Zero latency, no flow control.
module shift_unit
  import shift_pkg::*;
#(
  parameter int N = SHIFT_N
) (
  input  logic [N-1:0]         operand,
  input  logic [$clog2(N)-1:0] shamt,
  input  logic [1:0]           op,
  output logic [N-1:0]         result,
  output logic                 err
);

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (shift_op_t'(op))
      OP_SLL:  result = operand << shamt;
      OP_SRL:  result = operand >> shamt;
      OP_SRA:  result = N'($signed(operand) >>> shamt);
      default: err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter for two requesters into one shift unit and output register; 1-cycle latency.
// Readies drop while the held result is stalled; SHIFT_ARBITER_STATS_EN adds per-requester grant counters.
module shift_arbiter
  import shift_pkg::*;
#(
  parameter int N = SHIFT_N
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [N-1:0]         a_data,
  input  logic [$clog2(N)-1:0] a_shamt,
  input  logic [1:0]           a_op,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [N-1:0]         b_data,
  input  logic [$clog2(N)-1:0] b_shamt,
  input  logic [1:0]           b_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_data,
  output logic                 out_id,
  output logic                 out_err
`ifdef SHIFT_ARBITER_STATS_EN
  ,
  output logic [15:0]          grant_cnt_a,
  output logic [15:0]          grant_cnt_b
`endif
);

  logic                 accept;
  logic                 grant_a;
  logic                 grant_b;
  logic                 a_fire;
  logic                 b_fire;
  // prio_b=1 means B wins the next contested cycle (A was granted last)
  logic                 prio_b;
  logic [N-1:0]         sel_data;
  logic [$clog2(N)-1:0] sel_shamt;
  logic [1:0]           sel_op;
  logic [N-1:0]         unit_res;
  logic                 unit_err;

  assign accept  = !out_valid || out_ready;
  assign grant_a = a_valid && (!b_valid || !prio_b);
  assign grant_b = b_valid && (!a_valid || prio_b);
  assign a_ready = accept && grant_a;
  assign b_ready = accept && grant_b;
  assign a_fire  = a_valid && a_ready;
  assign b_fire  = b_valid && b_ready;

  assign sel_data  = grant_b ? b_data  : a_data;
  assign sel_shamt = grant_b ? b_shamt : a_shamt;
  assign sel_op    = grant_b ? b_op    : a_op;

  shift_unit #(.N(N)) u_shift (
    .operand (sel_data),
    .shamt   (sel_shamt),
    .op      (sel_op),
    .result  (unit_res),
    .err     (unit_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= 1'b0;
      out_err   <= 1'b0;
      prio_b    <= 1'b0;
    end else if (a_fire || b_fire) begin
      out_valid <= 1'b1;
      out_data  <= unit_res;
      out_id    <= b_fire;
      out_err   <= unit_err;
      prio_b    <= a_fire;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SHIFT_ARBITER_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_a <= '0;
      grant_cnt_b <= '0;
    end else begin
      if (a_fire) grant_cnt_a <= grant_cnt_a + 16'd1;
      if (b_fire) grant_cnt_b <= grant_cnt_b + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: grants, shifts, stall, reserved op, async reset.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, b_valid, out_ready;
  logic        a_ready, b_ready;
  logic [31:0] a_data, b_data;
  logic [4:0]  a_shamt, b_shamt;
  logic [1:0]  a_op, b_op;
  logic        out_valid, out_id, out_err;
  logic [31:0] out_data;
`ifdef SHIFT_ARBITER_STATS_EN
  logic [15:0] grant_cnt_a, grant_cnt_b;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_arbiter #(.N(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_data    (a_data),
    .a_shamt   (a_shamt),
    .a_op      (a_op),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_data    (b_data),
    .b_shamt   (b_shamt),
    .b_op      (b_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_err   (out_err)
`ifdef SHIFT_ARBITER_STATS_EN
    ,
    .grant_cnt_a (grant_cnt_a),
    .grant_cnt_b (grant_cnt_b)
`endif
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 1'b0; a_data = '0; a_shamt = '0; a_op = 2'b00;
    b_valid = 1'b0; b_data = '0; b_shamt = '0; b_op = 2'b00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    out_ready = 1'b1;
    rst_n = 1'b0;
    #2;
    total++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_id !== 1'b0 || out_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: valid=%b data=%h id=%b err=%b, want 0 0 0 0",
               out_valid, out_data, out_id, out_err);
    end
`ifdef SHIFT_ARBITER_STATS_EN
    total++;
    if (grant_cnt_a !== 16'd0 || grant_cnt_b !== 16'd0) begin
      bad++;
      $display("FAIL reset_stats: a=%0d b=%0d, want 0 0", grant_cnt_a, grant_cnt_b);
    end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sra_single();
    a_valid = 1'b1; a_data = 32'h8000_0000; a_shamt = 5'd4; a_op = 2'b10;
    #1;
    total++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      bad++;
      $display("FAIL sra_ready: a_ready=%b b_ready=%b, want 1 0", a_ready, b_ready);
    end
    tick();
    idle();
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'hF800_0000 || out_id !== 1'b0 || out_err !== 1'b0) begin
      bad++;
      $display("FAIL sra_result: valid=%b data=%h id=%b err=%b, want 1 f8000000 0 0",
               out_valid, out_data, out_id, out_err);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain_empty: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_alternate();
    logic [31:0] exp_d;
    idle();
    do_reset();
    out_ready = 1'b1;
    a_valid = 1'b1; a_data = 32'h0000_0010; a_shamt = 5'd4; a_op = 2'b01;
    b_valid = 1'b1; b_data = 32'h0000_0010; b_shamt = 5'd4; b_op = 2'b00;
    for (int i = 0; i < 6; i++) begin
      #1;
      total++;
      if (a_ready !== (i % 2 == 0) || b_ready !== (i % 2 == 1)) begin
        bad++;
        $display("FAIL alt_grant[%0d]: a_ready=%b b_ready=%b, want %b %b",
                 i, a_ready, b_ready, i % 2 == 0, i % 2 == 1);
      end
      tick();
      exp_d = (i % 2 == 0) ? 32'h0000_0001 : 32'h0000_0100;
      total++;
      if (out_valid !== 1'b1 || out_id !== 1'(i % 2) || out_data !== exp_d) begin
        bad++;
        $display("FAIL alt_out[%0d]: valid=%b id=%b data=%h, want 1 %0d %h",
                 i, out_valid, out_id, out_data, i % 2, exp_d);
      end
    end
`ifdef SHIFT_ARBITER_STATS_EN
    total++;
    if (grant_cnt_a !== 16'd3 || grant_cnt_b !== 16'd3) begin
      bad++;
      $display("FAIL alt_stats: a=%0d b=%0d, want 3 3", grant_cnt_a, grant_cnt_b);
    end
`endif
    idle();
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL alt_drain: out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    b_valid = 1'b1; b_data = 32'h0000_0001; b_shamt = 5'd31; b_op = 2'b00;
    tick();
    a_valid = 1'b1; a_data = 32'h1111_1111; a_shamt = 5'd1; a_op = 2'b00;
    b_data = 32'h2222_2222;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0 || out_valid !== 1'b1 ||
          out_data !== 32'h8000_0000 || out_id !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold[%0d]: ar=%b br=%b valid=%b data=%h id=%b, want 0 0 1 80000000 1",
                 i, a_ready, b_ready, out_valid, out_data, out_id);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    // B was last granted, so A wins the first contested cycle after the stall
    total++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      bad++;
      $display("FAIL stall_release: a_ready=%b b_ready=%b, want 1 0", a_ready, b_ready);
    end
    tick();
    idle();
    total++;
    if (out_valid !== 1'b1 || out_id !== 1'b0 || out_data !== 32'h2222_2222) begin
      bad++;
      $display("FAIL stall_reload: valid=%b id=%b data=%h, want 1 0 22222222",
               out_valid, out_id, out_data);
    end
    tick();
  endtask

  task automatic test_shifts();
    out_ready = 1'b1;
    a_valid = 1'b1; a_data = 32'hFFFF_FFFF; a_shamt = 5'd7; a_op = 2'b11;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'h0 || out_err !== 1'b1 || out_id !== 1'b0) begin
      bad++;
      $display("FAIL rsv_op: valid=%b data=%h err=%b id=%b, want 1 0 1 0",
               out_valid, out_data, out_err, out_id);
    end
    a_data = 32'h1234_5678; a_shamt = 5'd0; a_op = 2'b01;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'h1234_5678 || out_err !== 1'b0) begin
      bad++;
      $display("FAIL srl_zero: valid=%b data=%h err=%b, want 1 12345678 0",
               out_valid, out_data, out_err);
    end
    idle();
    b_valid = 1'b1; b_data = 32'h8000_0000; b_shamt = 5'd8; b_op = 2'b01;
    tick();
    total++;
    if (out_data !== 32'h0080_0000 || out_id !== 1'b1 || out_err !== 1'b0) begin
      bad++;
      $display("FAIL srl_fill: data=%h id=%b err=%b, want 00800000 1 0", out_data, out_id, out_err);
    end
    b_data = 32'h7000_0000; b_shamt = 5'd4; b_op = 2'b10;
    tick();
    total++;
    if (out_data !== 32'h0700_0000) begin
      bad++;
      $display("FAIL sra_pos: data=%h, want 07000000", out_data);
    end
    b_data = 32'hABCD_EF01; b_shamt = 5'd31; b_op = 2'b10;
    tick();
    total++;
    if (out_data !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL sra_max: data=%h, want ffffffff", out_data);
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid_full();
    out_ready = 1'b0;
    a_valid = 1'b1; a_data = 32'h0000_00F0; a_shamt = 5'd4; a_op = 2'b00;
    tick();
    idle();
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'h0000_0F00) begin
      bad++;
      $display("FAIL pre_reset_full: valid=%b data=%h, want 1 00000f00", out_valid, out_data);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_id !== 1'b0 || out_err !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: valid=%b data=%h id=%b err=%b, want 0 0 0 0",
               out_valid, out_data, out_id, out_err);
    end
`ifdef SHIFT_ARBITER_STATS_EN
    total++;
    if (grant_cnt_a !== 16'd0 || grant_cnt_b !== 16'd0) begin
      bad++;
      $display("FAIL async_reset_stats: a=%0d b=%0d, want 0 0", grant_cnt_a, grant_cnt_b);
    end
`endif
    rst_n = 1'b1;
    out_ready = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    total++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_grant: a_ready=%b b_ready=%b, want 1 0", a_ready, b_ready);
    end
    tick();
    idle();
    tick();
  endtask

  initial begin
    idle();
    out_ready = 1'b1;
    rst_n = 1'b1;
    #2;
    test_reset();
    test_sra_single();
    test_alternate();
    test_stall();
    test_shifts();
    test_reset_mid_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
